// File: rtl/td4_prog_mem_if.sv
// rtl/td4_prog_mem_if.sv - program-load byte stream between loader and program memory
interface td4_prog_mem_if #(
  parameter int DATA_W = 8
) ();
  logic              load_start;
  logic [DATA_W-1:0] ld_data;
  logic              ld_valid;
  logic              ld_ready;

  modport master (output load_start, ld_data, ld_valid, input ld_ready);
  modport slave  (input load_start, ld_data, ld_valid, output ld_ready);
endinterface

// File: rtl/td4_prog_mem.sv
// rtl/td4_prog_mem.sv - TD4 program memory with checksum-verified stream loader
// Holds the core in reset until a full program plus a zero-sum checksum byte has been accepted.
module td4_prog_mem #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] adr,
  output logic [DATA_W-1:0] instr,
  td4_prog_mem_if.slave     ld,
  output logic              cpu_reset,
  output logic              loaded,
  output logic              load_done,
  output logic              ld_error
);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [2:0] {
    S_HOLD,
    S_LOAD,
    S_CHECK,
    S_RELEASE,
    S_RUN
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [DATA_W-1:0] sum_q, sum_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              we;
  logic              xfer;
  logic [DATA_W-1:0] sum_chk;

  assign xfer    = ld.ld_valid & ld.ld_ready;
  assign sum_chk = sum_q + ld.ld_data;

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    sum_d   = sum_q;
    err_d   = err_q;
    we      = 1'b0;
    if (ld.load_start) begin
      // restart wins over any transfer presented in the same cycle
      state_d = S_LOAD;
      wptr_d  = '0;
      sum_d   = '0;
      err_d   = 1'b0;
    end else begin
      unique case (state_q)
        S_LOAD: begin
          if (xfer) begin
            we     = 1'b1;
            sum_d  = sum_chk;
            wptr_d = wptr_q + 1'b1;
            if (&wptr_q) state_d = S_CHECK;
          end
        end
        S_CHECK: begin
          if (xfer) begin
            if (sum_chk == '0) begin
              state_d = S_RELEASE;
            end else begin
              state_d = S_HOLD;
              err_d   = 1'b1;
            end
          end
        end
        S_RELEASE: state_d = S_RUN;
        default:   state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_HOLD;
      wptr_q  <= '0;
      sum_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      sum_q   <= sum_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we) begin
      mem_q[wptr_q] <= ld.ld_data;
    end
  end

  assign instr       = mem_q[adr];
  assign ld.ld_ready = (state_q == S_LOAD) || (state_q == S_CHECK);
  assign cpu_reset   = (state_q != S_RUN);
  assign loaded      = (state_q == S_RELEASE) || (state_q == S_RUN);
  assign load_done   = (state_q == S_RELEASE);
  assign ld_error    = err_q;
endmodule

// File: tb/tb_td4_prog_mem.sv
// tb/tb_td4_prog_mem.sv - self-checking bench for td4_prog_mem
// Reference model tracks bytes still expected, running sum and flags per load.
module tb_td4_prog_mem;
  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] adr;
  logic [7:0] instr;
  logic       cpu_reset, loaded, load_done, ld_error;

  td4_prog_mem_if #(.DATA_W(8)) lif ();

  td4_prog_mem #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .adr       (adr),
    .instr     (instr),
    .ld        (lif.slave),
    .cpu_reset (cpu_reset),
    .loaded    (loaded),
    .load_done (load_done),
    .ld_error  (ld_error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] m_mem [16];
  int         m_need;
  int         m_sum;
  int         m_idx;
  bit         m_loaded, m_err, m_done;

  wire [4:0] dut_flags = {cpu_reset, loaded, load_done, ld_error, lif.ld_ready};

  function automatic logic [4:0] exp_flags();
    return {!(m_loaded && !m_done), m_loaded, m_done, m_err, (m_need > 0)};
  endfunction

  task automatic step(input bit rst, input bit st, input bit v,
                      input logic [7:0] d, input logic [3:0] a);
    reset = rst; lif.load_start = st; lif.ld_valid = v; lif.ld_data = d; adr = a;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
      m_need = 0; m_sum = 0; m_idx = 0; m_loaded = 0; m_err = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (st) begin
        m_need = 17; m_idx = 0; m_sum = 0; m_err = 0; m_loaded = 0;
      end else if (v && m_need > 1) begin
        m_mem[m_idx] = d; m_sum = (m_sum + d) % 256; m_idx++; m_need--;
      end else if (v && m_need == 1) begin
        m_need = 0;
        if ((m_sum + d) % 256 == 0) begin m_loaded = 1; m_done = 1; end
        else m_err = 1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    step(1, 0, 0, 8'h00, 4'd0);
    step(1, 0, 0, 8'h00, 4'd0);
    for (int a = 0; a < 16; a++) begin
      step(0, 0, 1, 8'($urandom), 4'(a));
      n_cmp++;
      if ({dut_flags, instr} !== {5'b10000, 8'h00}) begin
        n_bad++;
        $display("FAIL reset_sweep adr=%0d got flags=%b instr=%h want flags=10000 instr=00", a, dut_flags, instr);
      end
    end
  endtask

  task automatic test_load_ok();
    step(0, 1, 0, 8'h00, 4'($urandom));
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 1, 8'(i), 4'($urandom));
      n_cmp++;
      if ({dut_flags, instr} !== {exp_flags(), m_mem[adr]}) begin
        n_bad++;
        $display("FAIL load_ok_byte%0d got %b/%h want %b/%h", i, dut_flags, instr, exp_flags(), m_mem[adr]);
      end
    end
    step(0, 0, 1, 8'h88, 4'd0);
    n_cmp++;
    if ({load_done, cpu_reset, loaded} !== 3'b111) begin
      n_bad++;
      $display("FAIL load_ok_release got done/cpurst/loaded=%b%b%b want 111", load_done, cpu_reset, loaded);
    end
    step(0, 0, 0, 8'h00, 4'd5);
    n_cmp++;
    if ({load_done, cpu_reset, loaded, instr} !== {3'b001, 8'h05}) begin
      n_bad++;
      $display("FAIL load_ok_run got done/cpurst/loaded=%b%b%b instr=%h want 001 05", load_done, cpu_reset, loaded, instr);
    end
    step(0, 0, 0, 8'h00, 4'd15);
    n_cmp++;
    if (instr !== 8'h0F) begin
      n_bad++;
      $display("FAIL load_ok_adr15 got %h want 0f", instr);
    end
  endtask

  task automatic test_bad_csum();
    step(0, 1, 0, 8'h00, 4'd0);
    for (int i = 0; i < 16; i++) step(0, 0, 1, 8'(i), 4'd0);
    step(0, 0, 1, 8'h89, 4'd0);
    for (int c = 0; c < 3; c++) begin
      step(0, 0, 1, 8'($urandom), 4'($urandom));
      n_cmp++;
      if ({dut_flags, instr} !== {5'b10010, m_mem[adr]}) begin
        n_bad++;
        $display("FAIL bad_csum_hold got %b/%h want 10010/%h", dut_flags, instr, m_mem[adr]);
      end
    end
    step(0, 1, 0, 8'h00, 4'd0);
    n_cmp++;
    if (dut_flags !== 5'b10001) begin
      n_bad++;
      $display("FAIL bad_csum_restart got %b want 10001", dut_flags);
    end
  endtask

  task automatic test_toggle_valid();
    int sum;
    logic [7:0] d;
    sum = 0;
    step(0, 1, 0, 8'h00, 4'd0);
    for (int c = 0; c < 34; c++) begin
      if (c % 2 == 0) begin
        d = (c == 32) ? 8'((256 - sum) % 256) : 8'($urandom);
        sum = (sum + d) % 256;
        step(0, 0, 1, d, 4'($urandom));
      end else begin
        step(0, 0, 0, 8'($urandom), 4'($urandom));
      end
      n_cmp++;
      if ({dut_flags, instr} !== {exp_flags(), m_mem[adr]}) begin
        n_bad++;
        $display("FAIL toggle_c%0d got %b/%h want %b/%h", c, dut_flags, instr, exp_flags(), m_mem[adr]);
      end
    end
    n_cmp++;
    if ({cpu_reset, loaded} !== 2'b01) begin
      n_bad++;
      $display("FAIL toggle_loaded got cpurst/loaded=%b%b want 01", cpu_reset, loaded);
    end
    for (int c = 0; c < 8; c++) step(0, 0, 1, 8'($urandom), 4'd0);
    for (int a = 0; a < 16; a++) begin
      step(0, 0, 1, 8'($urandom), 4'(a));
      n_cmp++;
      if ({dut_flags, instr} !== {5'b01000, m_mem[a]}) begin
        n_bad++;
        $display("FAIL run_mem_adr%0d got %b/%h want 01000/%h", a, dut_flags, instr, m_mem[a]);
      end
    end
  endtask

  task automatic test_restart();
    int sum;
    step(0, 1, 0, 8'h00, 4'd0);
    for (int i = 0; i < 7; i++) step(0, 0, 1, 8'($urandom), 4'd0);
    step(0, 1, 1, 8'h55, 4'd0);
    sum = 0;
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 1, 8'(8'hA0 + i), 4'd0);
      sum = (sum + 8'hA0 + i) % 256;
    end
    step(0, 0, 1, 8'((256 - sum) % 256), 4'd0);
    step(0, 0, 0, 8'h00, 4'd0);
    n_cmp++;
    if ({loaded, instr} !== {1'b1, 8'hA0}) begin
      n_bad++;
      $display("FAIL restart_mem0 got loaded=%b instr=%h want 1 a0", loaded, instr);
    end
    step(0, 0, 0, 8'h00, 4'd15);
    n_cmp++;
    if ({loaded, cpu_reset, instr} !== {2'b10, 8'hAF}) begin
      n_bad++;
      $display("FAIL restart_mem15 got loaded=%b cpurst=%b instr=%h want 1 0 af", loaded, cpu_reset, instr);
    end
  endtask

  task automatic test_reset_mid_load();
    int sum;
    logic [7:0] d;
    step(0, 1, 0, 8'h00, 4'd0);
    for (int i = 0; i < 10; i++) step(0, 0, 1, 8'($urandom_range(1, 255)), 4'd0);
    step(1, 0, 1, 8'h33, 4'd0);
    for (int a = 0; a < 16; a++) begin
      step(0, 0, 1, 8'($urandom), 4'(a));
      n_cmp++;
      if ({dut_flags, instr} !== {5'b10000, 8'h00}) begin
        n_bad++;
        $display("FAIL midreset_adr%0d got %b/%h want 10000/00", a, dut_flags, instr);
      end
    end
    sum = 0;
    step(0, 1, 0, 8'h00, 4'd0);
    for (int i = 0; i < 16; i++) begin
      d = 8'($urandom);
      sum = (sum + d) % 256;
      step(0, 0, 1, d, 4'd0);
    end
    step(0, 0, 1, 8'((256 - sum) % 256), 4'd0);
    step(0, 0, 0, 8'h00, 4'($urandom));
    n_cmp++;
    if ({dut_flags, instr} !== {5'b01000, m_mem[adr]}) begin
      n_bad++;
      $display("FAIL midreset_reload got %b/%h want 01000/%h", dut_flags, instr, m_mem[adr]);
    end
  endtask

  task automatic test_random();
    int cyc;
    logic [7:0] d;
    for (int it = 0; it < 6; it++) begin
      step(0, 1, 0, 8'h00, 4'd0);
      cyc = 0;
      while (m_need > 0 && cyc < 300) begin
        d = 8'($urandom);
        if (m_need == 1 && $urandom_range(0, 3) != 0) d = 8'((256 - m_sum) % 256);
        step(0, ($urandom_range(0, 59) == 0), ($urandom_range(0, 9) < 7), d, 4'($urandom));
        cyc++;
        n_cmp++;
        if ({dut_flags, instr} !== {exp_flags(), m_mem[adr]}) begin
          n_bad++;
          $display("FAIL random_it%0d_c%0d got %b/%h want %b/%h", it, cyc, dut_flags, instr, exp_flags(), m_mem[adr]);
        end
      end
      for (int c = 0; c < 4; c++) begin
        step(0, 0, 1, 8'($urandom), 4'($urandom));
        n_cmp++;
        if ({dut_flags, instr} !== {exp_flags(), m_mem[adr]}) begin
          n_bad++;
          $display("FAIL random_tail_it%0d got %b/%h want %b/%h", it, dut_flags, instr, exp_flags(), m_mem[adr]);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; lif.load_start = 1'b0; lif.ld_valid = 1'b0; lif.ld_data = 8'h00; adr = 4'd0;
    test_reset();
    test_load_ok();
    test_bad_csum();
    test_toggle_valid();
    test_restart();
    test_reset_mid_load();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
